block2x2_mac: RTL and testbench

- Sequential 2x2 block multiply-accumulate unit. It is the downstream consumer of the blocked matrix-multiply controller.
- The controller fetches a 2x2 block of the first matrix (A) and a 2x2 block of the second matrix (B) and hands them to one of three identical instances. Each instance's in_ready drives that controller's per-instance "mul ready" flag.
- The unit accumulates C += A*B over successive blocks along the shared dimension. After the last block it presents the 2x2 result for write-back.
- One shared multiplier is used, giving 8 MAC cycles per block.

---
 rtl/block2x2_mac.sv | 151 +++++++++++++++
 tb/tb_block2x2_mac.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/block2x2_mac.sv
// ============================================================================
// Module   : block2x2_mac
// Purpose  : Sequential 2x2 block multiply-accumulate. Accumulates C += A*B
//            over successive blocks using one shared multiplier (8 MACs per
//            block) and presents the 2x2 result after the last block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module block2x2_mac #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] a_ul,
  input  logic [DATA_WIDTH-1:0] a_ur,
  input  logic [DATA_WIDTH-1:0] a_dl,
  input  logic [DATA_WIDTH-1:0] a_dr,
  input  logic [DATA_WIDTH-1:0] b_ul,
  input  logic [DATA_WIDTH-1:0] b_ur,
  input  logic [DATA_WIDTH-1:0] b_dl,
  input  logic [DATA_WIDTH-1:0] b_dr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] c_ul,
  output logic [DATA_WIDTH-1:0] c_ur,
  output logic [DATA_WIDTH-1:0] c_dl,
  output logic [DATA_WIDTH-1:0] c_dr,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                r_state;
  logic [2:0]            r_step;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_a_ul, r_a_ur, r_a_dl, r_a_dr;
  logic [DATA_WIDTH-1:0] r_b_ul, r_b_ur, r_b_dl, r_b_dr;
  logic [DATA_WIDTH-1:0] r_acc_ul, r_acc_ur, r_acc_dl, r_acc_dr;

  logic [DATA_WIDTH-1:0] w_mul_a;
  logic [DATA_WIDTH-1:0] w_mul_b;
  logic [DATA_WIDTH-1:0] w_prod_lo;
  logic [DATA_WIDTH-1:0] w_acc_sel;
  logic [DATA_WIDTH-1:0] w_acc_sum;

  assign in_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);

  // Route the operand pair and target accumulator for the current MAC step.
  always_comb begin
    w_mul_a   = '0;
    w_mul_b   = '0;
    w_acc_sel = '0;
    case (r_step)
      3'd0: begin w_mul_a = r_a_ul; w_mul_b = r_b_ul; end
      3'd1: begin w_mul_a = r_a_ur; w_mul_b = r_b_dl; end
      3'd2: begin w_mul_a = r_a_ul; w_mul_b = r_b_ur; end
      3'd3: begin w_mul_a = r_a_ur; w_mul_b = r_b_dr; end
      3'd4: begin w_mul_a = r_a_dl; w_mul_b = r_b_ul; end
      3'd5: begin w_mul_a = r_a_dr; w_mul_b = r_b_dl; end
      3'd6: begin w_mul_a = r_a_dl; w_mul_b = r_b_ur; end
      default: begin w_mul_a = r_a_dr; w_mul_b = r_b_dr; end
    endcase
    case (r_step[2:1])
      2'd0:    w_acc_sel = r_acc_ul;
      2'd1:    w_acc_sel = r_acc_ur;
      2'd2:    w_acc_sel = r_acc_dl;
      default: w_acc_sel = r_acc_dr;
    endcase
  end

  // Only the low DATA_WIDTH bits of the signed double-width product are
  // accumulated; those bits are identical for a signed or unsigned multiply
  // truncated to DATA_WIDTH, so the narrow product is computed directly.
  assign w_prod_lo = w_mul_a * w_mul_b;
  assign w_acc_sum = w_acc_sel + w_prod_lo;

  // Control FSM, operand latches, accumulators and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_step    <= '0;
      r_last    <= 1'b0;
      r_a_ul    <= '0; r_a_ur <= '0; r_a_dl <= '0; r_a_dr <= '0;
      r_b_ul    <= '0; r_b_ur <= '0; r_b_dl <= '0; r_b_dr <= '0;
      r_acc_ul  <= '0; r_acc_ur <= '0; r_acc_dl <= '0; r_acc_dr <= '0;
      c_ul      <= '0; c_ur <= '0; c_dl <= '0; c_dr <= '0;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_ul <= a_ul; r_a_ur <= a_ur; r_a_dl <= a_dl; r_a_dr <= a_dr;
            r_b_ul <= b_ul; r_b_ur <= b_ur; r_b_dl <= b_dl; r_b_dr <= b_dr;
            r_last <= in_last;
            if (in_first) begin
              r_acc_ul <= '0; r_acc_ur <= '0; r_acc_dl <= '0; r_acc_dr <= '0;
            end
            r_step  <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          case (r_step[2:1])
            2'd0:    r_acc_ul <= w_acc_sum;
            2'd1:    r_acc_ur <= w_acc_sum;
            2'd2:    r_acc_dl <= w_acc_sum;
            default: r_acc_dr <= w_acc_sum;
          endcase
          r_step <= r_step + 3'd1;
          if (r_step == 3'd7) begin
            if (r_last) begin
              // The final step updates acc_dr, so take its fresh sum.
              c_ul      <= r_acc_ul;
              c_ur      <= r_acc_ur;
              c_dl      <= r_acc_dl;
              c_dr      <= w_acc_sum;
              out_valid <= 1'b1;
              r_state   <= OUT;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_acc_ul  <= '0; r_acc_ur <= '0; r_acc_dl <= '0; r_acc_dr <= '0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_block2x2_mac.sv
// ============================================================================
// Module   : tb_block2x2_mac
// Purpose  : Directed self-checking bench for block2x2_mac.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block2x2_mac;

  localparam int DATA_WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid, in_ready, in_first, in_last;
  logic [DATA_WIDTH-1:0] a_ul, a_ur, a_dl, a_dr;
  logic [DATA_WIDTH-1:0] b_ul, b_ur, b_dl, b_dr;
  logic                  out_valid, out_ready, busy;
  logic [DATA_WIDTH-1:0] c_ul, c_ur, c_dl, c_dr;

  int n_checks = 0;
  int n_fails  = 0;

  block2x2_mac #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last),
    .a_ul(a_ul), .a_ur(a_ur), .a_dl(a_dl), .a_dr(a_dr),
    .b_ul(b_ul), .b_ur(b_ur), .b_dl(b_dl), .b_dr(b_dr),
    .out_valid(out_valid), .out_ready(out_ready),
    .c_ul(c_ul), .c_ur(c_ur), .c_dl(c_dl), .c_dr(c_dr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one block at a negedge and hold it across the accept edge.
  task automatic send_block(input logic [31:0] a0, a1, a2, a3,
                            input logic [31:0] b0, b1, b2, b3,
                            input logic first, input logic last);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", 32'(in_ready), 32'd1);
    a_ul = a0; a_ur = a1; a_dl = a2; a_dr = a3;
    b_ul = b0; b_ur = b1; b_dl = b2; b_dr = b3;
    in_first = first; in_last = last; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count cycles (from the accept edge) until out_valid is seen.
  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic check_c(input logic [31:0] e_ul, e_ur, e_dl, e_dr);
    check("c_ul", c_ul, e_ul);
    check("c_ur", c_ur, e_ur);
    check("c_dl", c_dl, e_dl);
    check("c_dr", c_dr, e_dr);
  endtask

  // Complete the result handshake and confirm return to IDLE.
  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_out_valid", 32'(out_valid), 32'd0);
    check("hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cnt;
    logic seen;
    reset = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    a_ul = '0; a_ur = '0; a_dl = '0; a_dr = '0;
    b_ul = '0; b_ur = '0; b_dl = '0; b_dr = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_c(32'd0, 32'd0, 32'd0, 32'd0);

    // 1: single block, first and last together.
    send_block(1, 2, 3, 4, 5, 6, 7, 8, 1'b1, 1'b1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_in_ready", 32'(in_ready), 32'd0);
    wait_out(cnt);
    check("t1_latency", 32'(cnt), 32'd8);
    check_c(32'd19, 32'd22, 32'd43, 32'd50);
    handshake();

    // 2: two blocks accumulated along the shared dimension.
    send_block(1, 2, 3, 4, 5, 6, 7, 8, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("t2_no_out_valid", 32'(seen), 32'd0);
    check("t2_idle_after_b1", 32'(in_ready), 32'd1);
    send_block(1, 0, 0, 1, 1, 1, 1, 1, 1'b0, 1'b1);
    wait_out(cnt);
    check("t2_latency", 32'(cnt), 32'd8);
    check_c(32'd20, 32'd23, 32'd44, 32'd51);
    handshake();

    // 3: signed product and wrap-around.
    send_block(32'hFFFF_FFFF, 0, 0, 0, 3, 0, 0, 0, 1'b1, 1'b1);
    wait_out(cnt);
    check_c(32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0);
    handshake();
    send_block(32'h0001_0000, 0, 0, 0, 32'h0001_0000, 0, 0, 0, 1'b1, 1'b1);
    wait_out(cnt);
    check_c(32'd0, 32'd0, 32'd0, 32'd0);
    handshake();

    // 4: backpressure holds the result; in_valid during OUT is ignored.
    send_block(1, 2, 3, 4, 5, 6, 7, 8, 1'b1, 1'b1);
    wait_out(cnt);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a_ul = 32'd9; b_ul = 32'd9; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_ready", 32'(in_ready), 32'd0);
      check("t4_hold_c_ul", c_ul, 32'd19);
      check("t4_hold_c_dr", c_dr, 32'd50);
    end
    handshake();
    check("t4_busy_after", 32'(busy), 32'd0);

    // 5: asynchronous reset during CALC step 3.
    send_block(1, 2, 3, 4, 5, 6, 7, 8, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    send_block(2, 0, 0, 2, 3, 0, 0, 3, 1'b0, 1'b1);
    wait_out(cnt);
    check("t5_latency", 32'(cnt), 32'd8);
    check_c(32'd6, 32'd0, 32'd0, 32'd6);
    handshake();

    // 6: back-to-back without in_first; early out_ready has no effect.
    out_ready = 1'b1;
    send_block(1, 2, 3, 4, 5, 6, 7, 8, 1'b0, 1'b1);
    wait_out(cnt);
    check("t6_latency", 32'(cnt), 32'd8);
    check_c(32'd19, 32'd22, 32'd43, 32'd50);
    @(negedge clk);
    check("t6_hs_out_valid", 32'(out_valid), 32'd0);
    check("t6_hs_in_ready", 32'(in_ready), 32'd1);
    check("t6_c_kept", c_ul, 32'd19);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
